iis_tx_fifo: RTL and testbench
==============================

IIS_TX_FIFO -- requirements
Module: iis_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, >= 4).
REQ-002 SHALL have parameter AW, default 4, pointer width = log2(DEPTH).
REQ-003 SHALL have parameter THRESH, default 4, almost-empty level.
REQ-004 SHALL have port clk  input  1  APB clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  stream enable from control register.
REQ-007 SHALL have port clr  input  1  synchronous flush pulse.
REQ-008 SHALL have port wr_valid  input  1  APB write strobe for one stereo frame.
REQ-009 SHALL have port wr_data  input  32  frame; [31:16] left, [15:0] right.
REQ-010 SHALL have port wr_ready  output  1  frame can be accepted.
REQ-011 SHALL have port rd_req  input  1  one-cycle pulse from the serializer requesting the next 16-bit word.
REQ-012 SHALL have port rd_data  output  16  word to serializer.
REQ-013 SHALL have port rd_ws  output  1  channel of rd_data; 1 = left, 0 = right.
REQ-014 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data/rd_ws updated.
REQ-015 SHALL have port level  output  AW+1  stored frames.
REQ-016 SHALL have ports full, empty, almost_empty  output  1 each  status.
REQ-017 SHALL have ports ovf, udf  output  1 each  sticky overflow/underflow flags.
REQ-018 SHALL have port clr_flags  input  1  clears ovf/udf.

Function
REQ-019 Storage: DEPTH x 32 circular buffer, wr/rd pointers AW bits, wrap DEPTH-1 -> 0.
REQ-020 wr_ready = !full, combinational from registered state; write accepted when wr_valid & wr_ready.
REQ-021 Write with full=1: frame dropped, ovf set next cycle, level unchanged.
REQ-022 Half-select state: LEFT_NEXT, RIGHT_NEXT; reset/flush/en=0 -> LEFT_NEXT.
REQ-023 rd_req ignored when en=0; rd_valid stays 0.
REQ-024 rd_req in LEFT_NEXT, not empty: pop one frame; rd_data <= frame[31:16], rd_ws <= 1, hold register <= frame[15:0]; -> RIGHT_NEXT.
REQ-025 rd_req in LEFT_NEXT, empty: no pop; rd_data <= 0, rd_ws <= 1, hold <= 0, udf set; -> RIGHT_NEXT.
REQ-026 rd_req in RIGHT_NEXT: rd_data <= hold, rd_ws <= 0, no pop; -> LEFT_NEXT (right half never sourced from a later frame).
REQ-027 Latency: rd_data, rd_ws, rd_valid registered, valid the cycle after rd_req; rd_valid high exactly one cycle per accepted rd_req.
REQ-028 Same-cycle write and pop: level unchanged, both take effect; write still requires full=0 at cycle start (no pass-through when full).
REQ-029 Same-cycle write and left rd_req while empty: underflow per REQ-025; written frame stored, served at next left request (no bypass).
REQ-030 level = frames stored, 0..DEPTH; full = level==DEPTH; empty = level==0; almost_empty = level<=THRESH.
REQ-031 ovf/udf remain set until clr_flags or clr; set event and clr_flags same cycle: flag ends cleared.
REQ-032 clr: pointers, level, hold, rd_data -> 0; half -> LEFT_NEXT; ovf/udf cleared; overrides write and rd_req same cycle; rd_valid 0 that cycle.
REQ-033 Stored memory contents need no clear; never observable after flush.

Reset
REQ-034 rstn low: pointers, level, hold, rd_data, rd_ws, rd_valid, ovf, udf = 0; half = LEFT_NEXT; empty=1, almost_empty=1, full=0, wr_ready=1.
REQ-035 Reset asserted mid-stream SHALL discard all frames; first rd_req after release underflows per REQ-025.

Verification
REQ-036 Write 0x1111_2222, 0x3333_4444; en=1; 4 rd_req pulses -> rd_data 0x1111(ws1), 0x2222(ws0), 0x3333(ws1), 0x4444(ws0), each one cycle after request; level 2->1->0.
REQ-037 Fill 16 frames -> full=1, wr_ready=0, level=16; 17th write -> ovf=1, contents unchanged; drain reads back frames 1..16 in order across pointer wrap.
REQ-038 Empty FIFO, rd_req -> rd_data 0, ws 1, udf=1; write 0xAAAA_BBBB, rd_req -> 0x0000 ws0 (not 0xBBBB); next rd_req -> 0xAAAA ws1.
REQ-039 level=16, write and left rd_req same cycle -> write dropped, ovf=1, level 15; level=5, same event -> level 5.
REQ-040 Mid-frame (RIGHT_NEXT, level 3) pulse clr with wr_valid and rd_req -> level 0, rd_valid 0, flags 0, next rd_req returns left channel (ws 1).
REQ-041 Assert rstn low with level 8, release -> all REQ-034 values; en=0 with rd_req pulses -> no rd_valid, level unchanged.

Source files
------------

// File: rtl/iis_tx_fifo.sv
// Transmit FIFO for an I2S serializer: stores 32-bit stereo frames written over APB
// and hands them out as alternating left/right 16-bit words on serializer request.
module iis_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          clr,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  output logic          wr_ready,
  input  logic          rd_req,
  output logic [15:0]   rd_data,
  output logic          rd_ws,
  output logic          rd_valid,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          almost_empty,
  output logic          ovf,
  output logic          udf,
  input  logic          clr_flags
);

  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_L = (AW+1)'(THRESH);
  localparam logic [AW:0] ONE_L    = (AW+1)'(1);

  typedef enum logic {
    LEFT_NEXT  = 1'b0,
    RIGHT_NEXT = 1'b1
  } half_e;

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [15:0]   hold_r;
  half_e         half_r;
  logic [15:0]   rd_data_r;
  logic          rd_ws_r;
  logic          rd_valid_r;
  logic          ovf_r;
  logic          udf_r;

  logic          full_s;
  logic          empty_s;
  logic          rd_take_s;
  logic          left_take_s;
  logic          push_s;
  logic          pop_s;
  logic          ovf_evt_s;
  logic          udf_evt_s;
  logic [31:0]   head_s;

  // Decode status and the per-cycle push/pop/error events; clr suppresses all of them.
  always_comb begin
    full_s      = (level_r == DEPTH_L);
    empty_s     = (level_r == {(AW+1){1'b0}});
    head_s      = mem_r[rd_ptr_r];
    rd_take_s   = rd_req & en & ~clr;
    left_take_s = rd_take_s & (half_r == LEFT_NEXT);
    push_s      = wr_valid & ~full_s & ~clr;
    pop_s       = left_take_s & ~empty_s;
    ovf_evt_s   = wr_valid & full_s & ~clr;
    udf_evt_s   = left_take_s & empty_s;
  end

  // Frame storage; contents are never cleared because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + ONE_L;
        2'b01:   level_r <= level_r - ONE_L;
        default: level_r <= level_r;
      endcase
    end
  end

  // Half-select FSM with registered serializer outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      half_r     <= LEFT_NEXT;
      hold_r     <= 16'h0000;
      rd_data_r  <= 16'h0000;
      rd_ws_r    <= 1'b0;
      rd_valid_r <= 1'b0;
    end else if (clr) begin
      half_r     <= LEFT_NEXT;
      hold_r     <= 16'h0000;
      rd_data_r  <= 16'h0000;
      rd_ws_r    <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_take_s;
      if (!en) begin
        half_r <= LEFT_NEXT;
      end else if (rd_take_s) begin
        case (half_r)
          LEFT_NEXT: begin
            // An empty FIFO yields a silent frame so the right half never comes from a later write.
            rd_data_r <= empty_s ? 16'h0000 : head_s[31:16];
            hold_r    <= empty_s ? 16'h0000 : head_s[15:0];
            rd_ws_r   <= 1'b1;
            half_r    <= RIGHT_NEXT;
          end
          RIGHT_NEXT: begin
            rd_data_r <= hold_r;
            rd_ws_r   <= 1'b0;
            half_r    <= LEFT_NEXT;
          end
          default: begin
            half_r <= LEFT_NEXT;
          end
        endcase
      end else begin
        half_r <= half_r;
      end
    end
  end

  // Sticky error flags; a clear request wins over a same-cycle set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (clr || clr_flags) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end
      if (udf_evt_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  assign wr_ready     = ~full_s;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_empty = (level_r <= THRESH_L);
  assign level        = level_r;
  assign rd_data      = rd_data_r;
  assign rd_ws        = rd_ws_r;
  assign rd_valid     = rd_valid_r;
  assign ovf          = ovf_r;
  assign udf          = udf_r;

endmodule

// File: tb/tb_iis_tx_fifo.sv
// Directed bench for iis_tx_fifo: hand-computed frames, halves, levels and flags.
module tb_iis_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int THRESH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic          clr;
  logic          wr_valid;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic [15:0]   rd_data;
  logic          rd_ws;
  logic          rd_valid;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          almost_empty;
  logic          ovf;
  logic          udf;
  logic          clr_flags;

  int checks   = 0;
  int failures = 0;
  logic [31:0] f;

  iis_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH)) dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_data(rd_data), .rd_ws(rd_ws), .rd_valid(rd_valid),
    .level(level), .full(full), .empty(empty), .almost_empty(almost_empty),
    .ovf(ovf), .udf(udf), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fr(input int k);
    return {16'h1000 + 16'(k), 16'h2000 + 16'(k)};
  endfunction

  task automatic status(input string tag, input int lvl);
    check({tag, ".level"}, 32'(level), 32'(lvl));
    check({tag, ".full"}, 32'(full), 32'(lvl == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(lvl == 0));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(lvl <= THRESH));
    check({tag, ".wr_ready"}, 32'(wr_ready), 32'(lvl != DEPTH));
  endtask

  task automatic wr(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] d, input logic ws);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    check({tag, ".valid"}, 32'(rd_valid), 32'd1);
    check({tag, ".data"}, 32'(rd_data), 32'(d));
    check({tag, ".ws"}, 32'(rd_ws), 32'(ws));
  endtask

  task automatic rd_frame(input string tag, input logic [31:0] fv);
    rd({tag, ".L"}, fv[31:16], 1'b1);
    rd({tag, ".R"}, fv[15:0], 1'b0);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_data = 32'h0;
    rd_req = 1'b0; clr_flags = 1'b0;
    cyc(); cyc();
    status("rst", 0);
    check("rst.rd_valid", 32'(rd_valid), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    check("rst.udf", 32'(udf), 32'd0);
    rstn = 1'b1;
    cyc();

    // Basic two-frame stream
    wr(32'h1111_2222);
    wr(32'h3333_4444);
    status("w2", 2);
    en = 1'b1;
    rd("b0", 16'h1111, 1'b1); status("b0", 1);
    rd("b1", 16'h2222, 1'b0); status("b1", 1);
    rd("b2", 16'h3333, 1'b1); status("b2", 0);
    rd("b3", 16'h4444, 1'b0); status("b3", 0);
    cyc();
    check("pulse.valid", 32'(rd_valid), 32'd0);

    // Fill across wrap, overflow, drain
    for (int k = 0; k < DEPTH; k++) begin
      wr(fr(k));
      status("fill", k + 1);
    end
    wr(32'hDEAD_BEEF);
    check("ovf.set", 32'(ovf), 32'd1);
    status("ovf", 16);
    for (int k = 0; k < DEPTH; k++) begin
      rd_frame("drain", fr(k));
    end
    status("drained", 0);
    clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
    check("ovf.clr", 32'(ovf), 32'd0);

    // Underflow and no-bypass
    rd("u0", 16'h0000, 1'b1);
    check("udf.set", 32'(udf), 32'd1);
    wr(32'hAAAA_BBBB);
    rd("nobyp", 16'h0000, 1'b0);
    rd("u1", 16'hAAAA, 1'b1);
    rd("u2", 16'hBBBB, 1'b0);
    clr_flags = 1'b1; cyc(); clr_flags = 1'b0;
    check("udf.clr", 32'(udf), 32'd0);
    clr_flags = 1'b1; rd_req = 1'b1; cyc(); clr_flags = 1'b0; rd_req = 1'b0;
    check("udfclr.valid", 32'(rd_valid), 32'd1);
    check("udfclr.udf", 32'(udf), 32'd0);
    rd("hold0", 16'h0000, 1'b0);

    // Simultaneous write and pop at full and at level 5
    for (int k = 0; k < DEPTH; k++) wr(fr(k));
    status("full2", 16);
    wr_valid = 1'b1; wr_data = 32'h5555_6666; rd_req = 1'b1;
    cyc();
    wr_valid = 1'b0; rd_req = 1'b0;
    f = fr(0);
    check("sf.data", 32'(rd_data), 32'(f[31:16]));
    check("sf.ovf", 32'(ovf), 32'd1);
    status("sf", 15);
    rd("sf.R", f[15:0], 1'b0);
    for (int k = 1; k <= 10; k++) rd_frame("mid", fr(k));
    status("l5", 5);
    wr_valid = 1'b1; wr_data = 32'h7777_8888; rd_req = 1'b1;
    cyc();
    wr_valid = 1'b0; rd_req = 1'b0;
    f = fr(11);
    check("s5.data", 32'(rd_data), 32'(f[31:16]));
    status("s5", 5);
    rd("s5.R", f[15:0], 1'b0);
    rd_frame("f12", fr(12));
    f = fr(13);
    rd("f13.L", f[31:16], 1'b1);
    status("l3", 3);
    check("preclr.ovf", 32'(ovf), 32'd1);

    // Flush mid-frame overrides write and read
    clr = 1'b1; wr_valid = 1'b1; wr_data = 32'h9999_9999; rd_req = 1'b1;
    cyc();
    clr = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    status("clr", 0);
    check("clr.valid", 32'(rd_valid), 32'd0);
    check("clr.data", 32'(rd_data), 32'd0);
    check("clr.ovf", 32'(ovf), 32'd0);
    check("clr.udf", 32'(udf), 32'd0);
    wr(32'hCAFE_F00D);
    rd_frame("postclr", 32'hCAFE_F00D);
    status("postclr", 0);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 8; k++) wr(fr(20 + k));
    status("l8", 8);
    f = fr(20);
    rd("pre.L", f[31:16], 1'b1);
    rstn = 1'b0;
    #1;
    status("arst", 0);
    check("arst.data", 32'(rd_data), 32'd0);
    check("arst.ws", 32'(rd_ws), 32'd0);
    cyc();
    rstn = 1'b1;
    cyc();
    rd("rel.L", 16'h0000, 1'b1);
    check("rel.udf", 32'(udf), 32'd1);
    rd("rel.R", 16'h0000, 1'b0);
    clr_flags = 1'b1; cyc(); clr_flags = 1'b0;

    // Disabled stream ignores requests and re-aligns to left
    wr(fr(30));
    wr(fr(31));
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; cyc(); rd_req = 1'b0;
      check("dis.valid", 32'(rd_valid), 32'd0);
      status("dis", 2);
    end
    en = 1'b1;
    f = fr(30);
    rd("en.L", f[31:16], 1'b1);
    en = 1'b0; cyc(); en = 1'b1;
    f = fr(31);
    rd("realign.L", f[31:16], 1'b1);
    status("end", 0);
    cyc();
    check("end.valid", 32'(rd_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
